// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: packs D/CB/B fields plus a range-checked signed
// immediate into a 32-bit word and streams it out with a byte address.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_type,
   input  logic [10:0]       in_opcode,
   input  logic [4:0]        in_rn,
   input  logic [4:0]        in_rt,
   input  logic [63:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              range_err,
   output logic [7:0]        err_count,
   output logic [15:0]       word_count
);

   localparam logic [1:0] TYPE_D  = 2'b00;
   localparam logic [1:0] TYPE_CB = 2'b01;
   localparam logic [1:0] TYPE_B  = 2'b10;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

   // The immediate fits when every bit above the field equals the field's sign bit.
   function automatic logic imm_fits(input logic [1:0] t, input logic [63:0] imm);
      logic ok;
      case (t)
         TYPE_D:  ok = (imm[63:8]  == {56{imm[8]}});
         TYPE_CB: ok = (imm[63:18] == {46{imm[18]}});
         TYPE_B:  ok = (imm[63:25] == {39{imm[25]}});
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] encode(input logic [1:0] t, input logic [10:0] op,
                                          input logic [4:0] rn, input logic [4:0] rt,
                                          input logic [63:0] imm);
      logic [31:0] w;
      case (t)
         TYPE_D:  w = {op, imm[8:0], 2'b00, rn, rt};
         TYPE_CB: w = {8'b1011_0100, imm[18:0], rt};
         TYPE_B:  w = {6'b00_0101, imm[25:0]};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
   logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
   logic              range_err_q, range_err_d;
   logic [7:0]        err_count_q, err_count_d;
   logic [15:0]       word_count_q, word_count_d;

   logic accept_s, fits_s, pass_s, fail_s, hs_s;

   assign in_ready = !out_valid_q || out_ready;
   assign accept_s = in_valid && in_ready;
   assign fits_s   = imm_fits(in_type, in_imm);
   assign pass_s   = accept_s && fits_s;
   assign fail_s   = accept_s && !fits_s;
   assign hs_s     = out_valid_q && out_ready;

   // Next-state for the output register, write address and counters.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_addr_d   = out_addr_q;
      wr_addr_d    = wr_addr_q;
      word_count_d = word_count_q;
      err_count_d  = err_count_q;
      range_err_d  = fail_s;

      if (hs_s) begin
         wr_addr_d    = wr_addr_q + STEP;
         word_count_d = word_count_q + 16'd1;
         out_valid_d  = 1'b0;
      end else begin
         wr_addr_d    = wr_addr_q;
      end

      // A loaded word takes the address after any handoff happening this cycle.
      if (pass_s) begin
         out_valid_d = 1'b1;
         out_instr_d = encode(in_type, in_opcode, in_rn, in_rt, in_imm);
         out_addr_d  = wr_addr_d;
      end else begin
         out_instr_d = out_instr_q;
      end

      if (fail_s && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end else begin
         err_count_d = err_count_q;
      end
   end

   // State registers with synchronous reset; a held word is dropped uncounted.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_instr_q  <= 32'h0000_0000;
         out_addr_q   <= BASE;
         wr_addr_q    <= BASE;
         range_err_q  <= 1'b0;
         err_count_q  <= 8'd0;
         word_count_q <= 16'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_addr_q   <= out_addr_d;
         wr_addr_q    <= wr_addr_d;
         range_err_q  <= range_err_d;
         err_count_q  <= err_count_d;
         word_count_q <= word_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_instr  = out_instr_q;
   assign out_addr   = out_addr_q;
   assign range_err  = range_err_q;
   assign err_count  = err_count_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: an 8-bit-address instance plus a 4-bit
// instance driven identically to exercise address wrap.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready, w_in_ready;
   logic [1:0]  in_type = 2'b00;
   logic [10:0] in_opcode = 11'h000;
   logic [4:0]  in_rn = 5'd0, in_rt = 5'd0;
   logic [63:0] in_imm = 64'd0;
   logic        out_ready = 1'b1;
   logic        out_valid, w_out_valid;
   logic [31:0] out_instr, w_out_instr;
   logic [7:0]  out_addr;
   logic [3:0]  w_out_addr;
   logic        range_err, w_range_err;
   logic [7:0]  err_count, w_err_count;
   logic [15:0] word_count, w_word_count;

   int n_checks = 0;
   int n_fail = 0;
   logic [39:0] exp_q[$];
   logic [3:0]  exp_w_q[$];
   logic [7:0]  model_addr = 8'd0;
   int          waited;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_opcode(in_opcode), .in_rn(in_rn), .in_rt(in_rt),
      .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .range_err(range_err),
      .err_count(err_count), .word_count(word_count));

   instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut_w (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_type(in_type), .in_opcode(in_opcode), .in_rn(in_rn), .in_rt(in_rt),
      .in_imm(in_imm), .out_valid(w_out_valid), .out_ready(out_ready),
      .out_instr(w_out_instr), .out_addr(w_out_addr), .range_err(w_range_err),
      .err_count(w_err_count), .word_count(w_word_count));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a handshake completes at the next posedge, so pop on the preceding negedge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", {32'd0, out_instr}, 64'hDEAD);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            check("out_instr", {32'd0, out_instr}, {32'd0, e[39:8]});
            check("out_addr", {56'd0, out_addr}, {56'd0, e[7:0]});
         end
      end
      if (!reset && w_out_valid && out_ready) begin
         if (exp_w_q.size() == 0) begin
            check("unexpected_wrap_word", {32'd0, w_out_instr}, 64'hDEAD);
         end else begin
            logic [3:0] ea;
            ea = exp_w_q.pop_front();
            check("wrap_out_addr", {60'd0, w_out_addr}, {60'd0, ea});
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      exp_w_q.delete();
      model_addr = 8'd0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Starts and ends at posedge+1; leaves in_valid high for back-to-back issue.
   task automatic send(input logic [1:0] t, input logic [10:0] op, input logic [4:0] rn,
                       input logic [4:0] rt, input logic [63:0] imm,
                       input bit exp_pass, input logic [31:0] exp_instr);
      bit acc;
      acc = 1'b0;
      waited = 0;
      in_valid = 1'b1; in_type = t; in_opcode = op; in_rn = rn; in_rt = rt; in_imm = imm;
      while (!acc && waited < 20) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            if (exp_pass) begin
               exp_q.push_back({exp_instr, model_addr});
               exp_w_q.push_back(model_addr[3:0]);
               model_addr = model_addr + 8'd4;
            end
         end else begin
            waited++;
         end
         @(posedge clk); #1;
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_err_pulse(input string name);
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_range_err"}, {63'd0, range_err}, 64'd1);
      check({name, "_no_valid"}, {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_range_err_clear"}, {63'd0, range_err}, 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_instr", {32'd0, out_instr}, 64'd0);
      check("rst_out_addr", {56'd0, out_addr}, 64'd0);
      check("rst_range_err", {63'd0, range_err}, 64'd0);
      check("rst_err_count", {56'd0, err_count}, 64'd0);
      check("rst_word_count", {48'd0, word_count}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;

      // D-type LDUR
      send(2'b00, 11'h7C2, 5'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 32'hF85F_8041);
      idle(3);
      check("d_word_count", {48'd0, word_count}, 64'd1);
      check("d_drained", 64'(exp_q.size()), 64'd0);

      // CB then B back to back
      do_reset();
      send(2'b01, 11'h000, 5'd0, 5'd5, 64'd3, 1'b1, 32'hB400_0065);
      check("cb_no_stall", 64'(waited), 64'd0);
      send(2'b10, 11'h000, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'h17FF_FFFF);
      check("b_no_stall", 64'(waited), 64'd0);
      idle(3);
      check("cbb_word_count", {48'd0, word_count}, 64'd2);
      check("cbb_drained", 64'(exp_q.size()), 64'd0);

      // Range errors, then the extreme in-range D immediates
      do_reset();
      send(2'b00, 11'h7C2, 5'd1, 5'd1, 64'd256, 1'b0, 32'h0);
      check_err_pulse("d_256");
      send(2'b10, 11'h000, 5'd0, 5'd0, 64'h0000_0000_0200_0000, 1'b0, 32'h0);
      check_err_pulse("b_2p25");
      check("err_count_2", {56'd0, err_count}, 64'd2);
      check("err_addr_same", {56'd0, out_addr}, 64'd0);
      send(2'b00, 11'h7C2, 5'd3, 5'd4, 64'hFFFF_FFFF_FFFF_FF00, 1'b1, 32'hF850_0064);
      send(2'b00, 11'h7C0, 5'd0, 5'd31, 64'd255, 1'b1, 32'hF80F_F01F);
      idle(3);
      check("imm_edge_drained", 64'(exp_q.size()), 64'd0);
      check("imm_edge_word_count", {48'd0, word_count}, 64'd2);

      // Backpressure
      do_reset();
      out_ready = 1'b0;
      send(2'b10, 11'h000, 5'd0, 5'd0, 64'd0, 1'b1, 32'h1400_0000);
      in_type = 2'b01; in_rt = 5'd0; in_imm = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", {63'd0, in_ready}, 64'd0);
         check("bp_out_valid", {63'd0, out_valid}, 64'd1);
         check("bp_out_instr", {32'd0, out_instr}, 64'h1400_0000);
         check("bp_out_addr", {56'd0, out_addr}, 64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(2'b01, 11'h000, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hB4FF_FFE0);
      check("bp_release_no_stall", 64'(waited), 64'd0);
      idle(3);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Address wrap on the 4-bit instance: 0,4,8,12,0
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(2'b10, 11'h000, 5'd0, 5'd0, 64'(i), 1'b1, 32'h1400_0000 + 32'(i));
      end
      idle(3);
      check("wrap_drained", 64'(exp_w_q.size()), 64'd0);
      check("wrap_word_count", {48'd0, w_word_count}, 64'd5);

      // Saturating error count
      do_reset();
      for (int i = 0; i < 300; i++) begin
         send(2'b11, 11'h7C2, 5'd1, 5'd1, 64'd0, 1'b0, 32'h0);
      end
      idle(2);
      check("sat_err_count", {56'd0, err_count}, 64'd255);
      check("sat_no_valid", {63'd0, out_valid}, 64'd0);

      // Reset with a word held
      out_ready = 1'b0;
      send(2'b10, 11'h000, 5'd0, 5'd0, 64'd7, 1'b1, 32'h1400_0007);
      idle(1);
      do_reset();
      out_ready = 1'b1;
      @(negedge clk);
      check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst2_out_addr", {56'd0, out_addr}, 64'd0);
      check("rst2_out_instr", {32'd0, out_instr}, 64'd0);
      check("rst2_err_count", {56'd0, err_count}, 64'd0);
      check("rst2_word_count", {48'd0, word_count}, 64'd0);
      @(posedge clk); #1;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
